dmd_tx: RTL and testbench



---
 rtl/dmd_tx.sv | 167 ++++++++++++++++
 tb/tb_dmd_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmd_tx.sv
// dmd_tx: streams a 1-bit frame buffer out as DMD serial signals (DOTCLK/SDATA/COLLATCH/ROWCLK/RDATA), rev 1.0
// Optional DMD_TX_TESTPAT_EN adds a test_pat input that replaces pixel data with a checkerboard.
`default_nettype none

module dmd_tx #(
  parameter int COLS     = 128,
  parameter int ROWS     = 32,
  parameter int DOTDIV   = 4,
  parameter int LATCH_W  = 2,
  parameter int ROW_HOLD = 64,
  parameter int AW       = $clog2(COLS*ROWS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
`ifdef DMD_TX_TESTPAT_EN
  input  logic          test_pat,
`endif
  output logic [AW-1:0] pix_addr,
  input  logic          pix_data,
  output logic          dmd_dotclk,
  output logic          dmd_sdata,
  output logic          dmd_collatch,
  output logic          dmd_rowclk,
  output logic          dmd_rowdata,
  output logic          frame_done,
  output logic          busy
);

  localparam int CB  = $clog2(COLS);
  localparam int RB  = $clog2(ROWS);
  localparam int MX1 = (DOTDIV > LATCH_W) ? DOTDIV : LATCH_W;
  localparam int MX  = (MX1 > ROW_HOLD) ? MX1 : ROW_HOLD;
  localparam int CW  = $clog2(MX + 1);
  localparam int HOLD_N = (ROW_HOLD > 0) ? ROW_HOLD : 1;

  localparam logic [CW-1:0] DOT_LAST   = CW'(DOTDIV - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_W - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    LATCH = 3'd4,
    HOLD  = 3'd5
  } state_t;

  state_t        state;
  logic [CB-1:0] col;
  logic [RB-1:0] row;
  logic [CW-1:0] cnt;

  logic last_col;
  logic last_row;
  logic row_end;
  logic bit_in;

  assign last_col = &col;
  assign last_row = &row;

  // With no hold time the row ends straight out of LATCH.
  assign row_end = ((state == HOLD) && (cnt == HOLD_LAST)) ||
                   ((state == LATCH) && (cnt == LATCH_LAST) && (ROW_HOLD == 0));

`ifdef DMD_TX_TESTPAT_EN
  assign bit_in = test_pat ? (col[0] ^ row[0]) : pix_data;
`else
  assign bit_in = pix_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      cnt          <= '0;
      pix_addr     <= '0;
      dmd_dotclk   <= 1'b0;
      dmd_sdata    <= 1'b0;
      dmd_collatch <= 1'b0;
      dmd_rowclk   <= 1'b0;
      dmd_rowdata  <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cnt        <= cnt + 1'b1;
      frame_done <= 1'b0;
      if (row_end) begin
        dmd_collatch <= 1'b0;
        dmd_rowclk   <= 1'b0;
        dmd_rowdata  <= 1'b0;
        frame_done   <= last_row;
        row          <= row + 1'b1;
        col          <= '0;
        cnt          <= '0;
        if (enable) begin
          state    <= FETCH;
          pix_addr <= {row + 1'b1, {CB{1'b0}}};
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (enable) begin
              state    <= FETCH;
              busy     <= 1'b1;
              pix_addr <= {row, col};
            end
          end
          FETCH: begin
            state <= LOW;
            cnt   <= '0;
          end
          LOW: begin
            // RAM output is valid during the first LOW cycle.
            if (cnt == '0) dmd_sdata <= bit_in;
            if (cnt == DOT_LAST) begin
              state      <= HIGH;
              cnt        <= '0;
              dmd_dotclk <= 1'b1;
            end
          end
          HIGH: begin
            if (cnt == DOT_LAST) begin
              dmd_dotclk <= 1'b0;
              cnt        <= '0;
              if (last_col) begin
                state        <= LATCH;
                dmd_collatch <= 1'b1;
                dmd_rowclk   <= 1'b1;
                dmd_rowdata  <= (row == '0);
                dmd_sdata    <= 1'b0;
              end else begin
                state    <= FETCH;
                col      <= col + 1'b1;
                pix_addr <= {row, col + 1'b1};
              end
            end
          end
          LATCH: begin
            if (cnt == LATCH_LAST) begin
              state        <= HOLD;
              cnt          <= '0;
              dmd_collatch <= 1'b0;
              dmd_rowclk   <= 1'b0;
              dmd_rowdata  <= 1'b0;
            end
          end
          HOLD: begin
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmd_tx.sv
// Bench for dmd_tx: RAM model plus row-level scoreboard of shifted bits, latches and timing.
`default_nettype none

module tb_dmd_tx;

  localparam int COLS     = 16;
  localparam int ROWS     = 4;
  localparam int DOTDIV   = 2;
  localparam int LATCH_W  = 2;
  localparam int ROW_HOLD = 3;
  localparam int AW       = $clog2(COLS*ROWS);
  localparam int NPIX     = COLS*ROWS;
  localparam int BITP     = 1 + 2*DOTDIV;
  localparam int ROWP     = COLS*BITP + LATCH_W + ROW_HOLD;
  localparam int LIM      = 3*ROWS*ROWP;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [AW-1:0] pix_addr;
  logic          pix_data;
  logic          dmd_dotclk, dmd_sdata, dmd_collatch, dmd_rowclk, dmd_rowdata;
  logic          frame_done, busy;
`ifdef DMD_TX_TESTPAT_EN
  logic          test_pat;
`endif

  dmd_tx #(
    .COLS(COLS), .ROWS(ROWS), .DOTDIV(DOTDIV), .LATCH_W(LATCH_W), .ROW_HOLD(ROW_HOLD), .AW(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
`ifdef DMD_TX_TESTPAT_EN
    .test_pat(test_pat),
`endif
    .pix_addr(pix_addr),
    .pix_data(pix_data),
    .dmd_dotclk(dmd_dotclk),
    .dmd_sdata(dmd_sdata),
    .dmd_collatch(dmd_collatch),
    .dmd_rowclk(dmd_rowclk),
    .dmd_rowdata(dmd_rowdata),
    .frame_done(frame_done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame buffer: synchronous read, one cycle latency.
  logic mem [NPIX];
  initial pix_data = 1'b0;
  always @(posedge clk) pix_data <= mem[pix_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int            nbits = 0, exp_row = 0, latches = 0, last_latch_cyc = 0, last_row = -1;
  int            first_rise = 0, last_rise = 0, lat_w = 0, dots = 0, nxt;
  logic [COLS-1:0] got, expb;
  logic          prev_dot = 1'b0, prev_lat = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  bit            tp_mode = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      nbits = 0; exp_row = 0; lat_w = 0;
      prev_dot = 1'b0; prev_lat = 1'b0; prev_addr = '0;
    end else begin
      if (dmd_dotclk && !prev_dot) begin
        if (nbits < COLS) got[nbits] = dmd_sdata;
        if (nbits == 0) first_rise = cyc;
        last_rise = cyc;
        nbits++;
        dots++;
      end
      if (pix_addr !== prev_addr) begin
        nxt = (int'(prev_addr) + 1) % NPIX;
        chk("addr_seq", 32'(pix_addr), nxt);
      end
      if (dmd_collatch && !prev_lat) begin
        for (int c = 0; c < COLS; c++)
          expb[c] = tp_mode ? (c[0] ^ exp_row[0]) : mem[exp_row*COLS + c];
        chk("row_bits", 32'(got), 32'(expb));
        chk("bit_count", nbits, COLS);
        chk("bit_span", last_rise - first_rise, (COLS-1)*BITP);
        chk("rowdata", 32'(dmd_rowdata), 32'(exp_row == 0));
        chk("latch_sdata", 32'(dmd_sdata), 0);
        latches++;
        last_latch_cyc = cyc;
        last_row = exp_row;
        exp_row = (exp_row + 1) % ROWS;
        nbits = 0;
        lat_w = 0;
      end
      if (dmd_collatch) lat_w++;
      else if (prev_lat) chk("latch_width", lat_w, LATCH_W);
      chk("rowclk_eq_latch", 32'(dmd_rowclk), 32'(dmd_collatch));
      chk("rowdata_gate", 32'(dmd_rowdata & ~dmd_collatch), 0);
      prev_dot = dmd_dotclk;
      prev_lat = dmd_collatch;
      prev_addr = pix_addr;
    end
  end

  task automatic wait_busy(input logic v, input string tag);
    int t = 0;
    while (busy !== v && t < LIM) begin @(negedge clk); t++; end
    chk({tag, "_timeout"}, 32'(t < LIM), 1);
  endtask

  task automatic wait_latches(input int n);
    int t = 0;
    while (latches < n && t < LIM) begin @(negedge clk); t++; end
    chk("latch_timeout", 32'(t < LIM), 1);
  endtask

  task automatic wait_fd();
    int t = 0;
    while (frame_done !== 1'b1 && t < LIM) begin @(negedge clk); t++; end
    chk("frame_done_timeout", 32'(t < LIM), 1);
  endtask

  task automatic wait_bits(input int r, input int k);
    int t = 0;
    while (!((r < 0 || exp_row == r) && nbits == k) && t < LIM) begin @(negedge clk); t++; end
    chk("bits_timeout", 32'(t < LIM), 1);
  endtask

  task automatic fill_mem(input int mode);
    for (int a = 0; a < NPIX; a++)
      case (mode)
        0:       mem[a] = 1'b1;
        1:       mem[a] = a[0];
        default: mem[a] = 1'($urandom);
      endcase
  endtask

  int t, f0, l0, d0, nr, k;
  logic [AW-1:0] a0;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
`ifdef DMD_TX_TESTPAT_EN
    test_pat = 1'b0;
`endif
    fill_mem(0);
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(pix_addr), 0);
    chk("rst_dotclk", 32'(dmd_dotclk), 0);
    chk("rst_sdata", 32'(dmd_sdata), 0);
    chk("rst_collatch", 32'(dmd_collatch), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);

    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // All-ones frame, first rows
    enable = 1'b1;
    wait_busy(1'b1, "start");
    chk("first_addr", 32'(pix_addr), 0);
    t = 0;
    while (dmd_dotclk !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("first_dot_latency", t, 1 + DOTDIV);
    wait_latches(2);

    // Asynchronous reset in the middle of a HIGH phase
    t = 0;
    while (dmd_dotclk !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_dotclk", 32'(dmd_dotclk), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_addr", 32'(pix_addr), 0);
    chk("rst_mid_sdata", 32'(dmd_sdata), 0);
    chk("rst_mid_collatch", 32'(dmd_collatch), 0);
    fill_mem(1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_busy(1'b1, "restart");
    chk("restart_addr", 32'(pix_addr), 0);

    // Address of row 3, col 5
    wait_bits(3, 5);
    a0 = pix_addr;
    t = 0;
    while (pix_addr === a0 && t < 100) begin @(negedge clk); t++; end
    chk("addr_r3c5", 32'(pix_addr), 3*COLS + 5);

    // Frame timing with enable held
    wait_fd();
    f0 = cyc;
    l0 = latches;
    chk("fd_after_latch", cyc - last_latch_cyc, LATCH_W + ROW_HOLD);
    chk("fd_last_row", last_row, ROWS - 1);
    @(negedge clk);
    chk("fd_pulse_width", 32'(frame_done), 0);
    wait_fd();
    chk("frame_period", cyc - f0, ROWS*ROWP);
    chk("latches_per_frame", latches - l0, ROWS);

    // Random stop points, random frame contents, resume at following row
    for (int it = 0; it < 3; it++) begin
      k = $urandom_range(COLS - 1, 1);
      wait_bits(-1, k);
      enable = 1'b0;
      l0 = latches;
      wait_busy(1'b0, "stop");
      chk("stop_row_latched", latches - l0, 1);
      chk("stop_busy_delay", cyc - last_latch_cyc, LATCH_W + ROW_HOLD);
      d0 = dots;
      nr = exp_row;
      repeat (20) @(negedge clk);
      chk("stop_no_dotclk", dots - d0, 0);
      chk("stop_busy_low", 32'(busy), 0);
      fill_mem(2);
      enable = 1'b1;
      wait_latches(l0 + 2);
      chk("resume_row", last_row, nr);
      wait_latches(l0 + 2 + ROWS);
    end

`ifdef DMD_TX_TESTPAT_EN
    enable = 1'b0;
    wait_busy(1'b0, "tp_stop");
    test_pat = 1'b1;
    tp_mode = 1'b1;
    l0 = latches;
    enable = 1'b1;
    wait_latches(l0 + ROWS);
    enable = 1'b0;
    wait_busy(1'b0, "tp_end");
    test_pat = 1'b0;
    tp_mode = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
